// File: rtl/acia_tx.sv
`default_nettype none
// ============================================================================
//  Module      : acia_tx
//  Description : Transmit section of a 6551-compatible ACIA. Holds one byte
//                in the Transmit Data Register and serialises it onto TXD as
//                start, 5-8 data bits (LSB first), optional parity and
//                1/1.5/2 stop bits, using 16 BCLK ticks per bit.
//  Revision    : 1.0  initial release
// ============================================================================
module acia_tx (
   input  logic       BCLK,
   input  logic       RESET,
   input  logic [7:0] TDR_DATA,
   input  logic       TDR_WR,
   input  logic [1:0] WL,
   input  logic       SBN,
   input  logic       PME,
   input  logic [1:0] PMC,
   input  logic       TX_BRK,
   input  logic       CTS_N,
   output logic       TXD,
   output logic       TDRE,
   output logic       TX_BUSY
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   // Last tick of a full 16-tick bit, and last tick of an 8-tick half bit.
   localparam logic [3:0] c_TICK_LAST = 4'd15;
   localparam logic [2:0] c_HALF_LAST = 3'd7;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_tdr;
   logic       r_tdre;
   logic [7:0] r_shift;
   logic [7:0] w_shift_nxt;
   logic [3:0] r_tick;
   logic [3:0] w_tick_nxt;
   logic [2:0] r_bit_cnt;       // data bit index, or stop half-bit index
   logic [2:0] w_bit_nxt;
   logic [2:0] r_last_bit;      // index of the final data bit of this frame
   logic       r_pme;
   logic       r_par_bit;
   logic [1:0] r_stop_last;     // number of stop half-bits minus one
   logic       r_txd;
   logic       w_txd_nxt;
   logic       w_load;
   logic       w_eval;

   logic [2:0] w_last_bit;
   logic [7:0] w_mask;
   logic [7:0] w_sent;
   logic       w_par_calc;
   logic [1:0] w_stop_last;

   // Decode the frame format from the live control inputs; used only at transfer.
   always_comb begin
      w_last_bit = 3'd7 - {1'b0, WL};
      case (WL)
         2'b00:   w_mask = 8'hFF;
         2'b01:   w_mask = 8'h7F;
         2'b10:   w_mask = 8'h3F;
         default: w_mask = 8'h1F;
      endcase
      // Unsent upper bits are masked to zero so they cannot disturb the parity.
      w_sent = r_tdr & w_mask;
      case (PMC)
         2'b00:   w_par_calc = ~^w_sent;
         2'b01:   w_par_calc = ^w_sent;
         2'b10:   w_par_calc = 1'b1;
         default: w_par_calc = 1'b0;
      endcase
      // Stop length in 8-tick halves: 2 = one bit, 3 = 1.5 bits, 4 = two bits.
      if (!SBN) begin
         w_stop_last = 2'd1;
      end else if ((WL == 2'b11) && !PME) begin
         w_stop_last = 2'd2;
      end else if ((WL == 2'b00) && PME) begin
         w_stop_last = 2'd1;
      end else begin
         w_stop_last = 2'd3;
      end
   end

   // Next-state, counters and serial output for the transmit sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick + 4'd1;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_load      = 1'b0;
      w_eval      = 1'b0;
      w_txd_nxt   = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_tick_nxt = 4'd0;
            w_eval     = 1'b1;
         end
         S_START: begin
            if (r_tick == c_TICK_LAST) begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = 3'd0;
            end
         end
         S_DATA: begin
            if (r_tick == c_TICK_LAST) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit_cnt == r_last_bit) begin
                  w_state_nxt = r_pme ? S_PARITY : S_STOP;
                  w_bit_nxt   = 3'd0;
               end else begin
                  w_bit_nxt   = r_bit_cnt + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (r_tick == c_TICK_LAST) begin
               w_state_nxt = S_STOP;
               w_bit_nxt   = 3'd0;
            end
         end
         S_STOP: begin
            // The stop period is counted in half bits so 1.5 stop bits fits.
            if (r_tick[2:0] == c_HALF_LAST) begin
               if (r_bit_cnt == {1'b0, r_stop_last}) begin
                  w_eval = 1'b1;
               end else begin
                  w_bit_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         S_BREAK: begin
            w_tick_nxt = 4'd0;
            if (!TX_BRK) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tick_nxt  = 4'd0;
         end
      endcase

      // Character-start decision: break first, then a pending byte with CTS.
      if (w_eval) begin
         w_tick_nxt = 4'd0;
         w_bit_nxt  = 3'd0;
         if (TX_BRK) begin
            w_state_nxt = S_BREAK;
         end else if (!r_tdre && !CTS_N) begin
            w_state_nxt = S_START;
            w_shift_nxt = r_tdr;
            w_load      = 1'b1;
         end else begin
            w_state_nxt = S_IDLE;
         end
      end

      case (w_state_nxt)
         S_START:  w_txd_nxt = 1'b0;
         S_DATA:   w_txd_nxt = w_shift_nxt[0];
         S_PARITY: w_txd_nxt = r_par_bit;
         S_STOP:   w_txd_nxt = 1'b1;
         S_BREAK:  w_txd_nxt = 1'b0;
         default:  w_txd_nxt = 1'b1;
      endcase
   end

   // Sequencer state, counters, shift register and registered TXD.
   always_ff @(posedge BCLK or negedge RESET) begin
      if (!RESET) begin
         r_state   <= S_IDLE;
         r_tick    <= 4'd0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
         r_txd     <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_tick    <= w_tick_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_txd     <= w_txd_nxt;
      end
   end

   // Transmit Data Register, its empty flag, and the per-frame format latch.
   always_ff @(posedge BCLK or negedge RESET) begin
      if (!RESET) begin
         r_tdr       <= 8'h00;
         r_tdre      <= 1'b1;
         r_last_bit  <= 3'd7;
         r_pme       <= 1'b0;
         r_par_bit   <= 1'b0;
         r_stop_last <= 2'd1;
      end else begin
         if (w_load) begin
            // A transfer only happens with the TDR full, so no write can land here.
            r_tdre      <= 1'b1;
            r_last_bit  <= w_last_bit;
            r_pme       <= PME;
            r_par_bit   <= w_par_calc;
            r_stop_last <= w_stop_last;
         end else if (TDR_WR && r_tdre) begin
            r_tdr  <= TDR_DATA;
            r_tdre <= 1'b0;
         end
      end
   end

   assign TXD     = r_txd;
   assign TDRE    = r_tdre;
   assign TX_BUSY = (r_state != S_IDLE);

endmodule
`default_nettype wire
